// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-interface definitions for the two-client request arbiter.
package mem_req_arbiter_pkg;

  localparam int ADDR_W = 26;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  // Beat counter width; a single-beat burst still needs one bit to hold a count.
  function automatic int cntWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of both client channels and the memory channel seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = mem_req_arbiter_pkg::ADDR_W,
  parameter int TAG_W  = mem_req_arbiter_pkg::TAG_W,
  parameter int DATA_W = mem_req_arbiter_pkg::DATA_W
);

  logic              c0_cmd_valid,  c1_cmd_valid;
  logic              c0_cmd_ready,  c1_cmd_ready;
  logic [ADDR_W-1:0] c0_cmd_addr,   c1_cmd_addr;
  logic [TAG_W-1:0]  c0_cmd_tag,    c1_cmd_tag;
  logic              c0_cmd_rw,     c1_cmd_rw;
  logic              c0_data_valid, c1_data_valid;
  logic              c0_data_ready, c1_data_ready;
  logic [DATA_W-1:0] c0_data_bits,  c1_data_bits;
  logic              c0_resp_valid, c1_resp_valid;
  logic [DATA_W-1:0] c0_resp_data,  c1_resp_data;
  logic [TAG_W-1:0]  c0_resp_tag,   c1_resp_tag;

  logic              mem_cmd_valid,  mem_cmd_ready;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [TAG_W:0]    mem_cmd_tag;
  logic              mem_cmd_rw;
  logic              mem_data_valid, mem_data_ready;
  logic [DATA_W-1:0] mem_data_bits;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic [TAG_W:0]    mem_resp_tag;

  modport slave (
    input  c0_cmd_valid, c0_cmd_addr, c0_cmd_tag, c0_cmd_rw,
    input  c1_cmd_valid, c1_cmd_addr, c1_cmd_tag, c1_cmd_rw,
    input  c0_data_valid, c0_data_bits, c1_data_valid, c1_data_bits,
    output c0_cmd_ready, c1_cmd_ready, c0_data_ready, c1_data_ready,
    output c0_resp_valid, c0_resp_data, c0_resp_tag,
    output c1_resp_valid, c1_resp_data, c1_resp_tag,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw,
    input  mem_cmd_ready,
    output mem_data_valid, mem_data_bits,
    input  mem_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport master (
    output c0_cmd_valid, c0_cmd_addr, c0_cmd_tag, c0_cmd_rw,
    output c1_cmd_valid, c1_cmd_addr, c1_cmd_tag, c1_cmd_rw,
    output c0_data_valid, c0_data_bits, c1_data_valid, c1_data_bits,
    input  c0_cmd_ready, c1_cmd_ready, c0_data_ready, c1_data_ready,
    input  c0_resp_valid, c0_resp_data, c0_resp_tag,
    input  c1_resp_valid, c1_resp_data, c1_resp_tag,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_tag, mem_cmd_rw,
    output mem_cmd_ready,
    input  mem_data_valid, mem_data_bits,
    output mem_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag
  );

endinterface

// File: rtl/mem_req_arbiter.sv
// Two-client round-robin memory request arbiter. Commands are arbitrated in
// IDLE; a granted write locks the data channel to its client for a full burst.
// Responses are steered back by the client index carried in the tag MSB.
module mem_req_arbiter #(
  parameter int ADDR_W = mem_req_arbiter_pkg::ADDR_W,
  parameter int TAG_W  = mem_req_arbiter_pkg::TAG_W,
  parameter int DATA_W = mem_req_arbiter_pkg::DATA_W,
  parameter int BEATS  = mem_req_arbiter_pkg::BEATS
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_req_arbiter_if.slave        bus
);

  import mem_req_arbiter_pkg::*;

  localparam int CNT_W = cntWidth(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t           r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [CNT_W-1:0] r_beatCnt;

  logic              w_anyReq;
  logic              w_winner;
  logic              w_cmdOpen;
  logic              w_dataOpen;
  logic              w_cmdFire;
  logic              w_dataFire;
  logic              w_ownerValid;
  logic [ADDR_W-1:0] w_cmdAddr;
  logic [TAG_W-1:0]  w_cmdTag;
  logic              w_cmdRw;
  logic [DATA_W-1:0] w_dataBits;

  // Round-robin pick: the client named by ptr wins if it requests, otherwise
  // the other one does. With no request the pick is irrelevant.
  assign w_anyReq = bus.c0_cmd_valid | bus.c1_cmd_valid;
  assign w_winner = r_ptr ? (bus.c1_cmd_valid | ~bus.c0_cmd_valid)
                          : (bus.c1_cmd_valid & ~bus.c0_cmd_valid);

  assign w_cmdAddr = w_winner ? bus.c1_cmd_addr : bus.c0_cmd_addr;
  assign w_cmdTag  = w_winner ? bus.c1_cmd_tag  : bus.c0_cmd_tag;
  assign w_cmdRw   = w_winner ? bus.c1_cmd_rw   : bus.c0_cmd_rw;

  assign w_ownerValid = r_owner ? bus.c1_data_valid : bus.c0_data_valid;
  assign w_dataBits   = r_owner ? bus.c1_data_bits  : bus.c0_data_bits;

  // Handshake outputs are silenced while reset is held so nothing is
  // accepted or offered during that window.
  assign w_cmdOpen  = (r_state == IDLE)  & ~reset;
  assign w_dataOpen = (r_state == WDATA) & ~reset;

  assign bus.mem_cmd_valid = w_cmdOpen & w_anyReq;
  assign bus.mem_cmd_addr  = w_cmdAddr;
  assign bus.mem_cmd_tag   = {w_winner, w_cmdTag};
  assign bus.mem_cmd_rw    = w_cmdRw;
  assign bus.c0_cmd_ready  = w_cmdOpen & ~w_winner & bus.mem_cmd_ready;
  assign bus.c1_cmd_ready  = w_cmdOpen &  w_winner & bus.mem_cmd_ready;

  assign bus.mem_data_valid = w_dataOpen & w_ownerValid;
  assign bus.mem_data_bits  = w_dataBits;
  assign bus.c0_data_ready  = w_dataOpen & ~r_owner & bus.mem_data_ready;
  assign bus.c1_data_ready  = w_dataOpen &  r_owner & bus.mem_data_ready;

  // Response steering is independent of the FSM and of reset.
  assign bus.c0_resp_valid = bus.mem_resp_valid & ~bus.mem_resp_tag[TAG_W];
  assign bus.c1_resp_valid = bus.mem_resp_valid &  bus.mem_resp_tag[TAG_W];
  assign bus.c0_resp_tag   = bus.mem_resp_tag[TAG_W-1:0];
  assign bus.c1_resp_tag   = bus.mem_resp_tag[TAG_W-1:0];
  assign bus.c0_resp_data  = bus.mem_resp_data;
  assign bus.c1_resp_data  = bus.mem_resp_data;

  // Transfer strobes exclude reset on purpose: the async reset branch below
  // already overrides them, and keeping reset out of flop data paths avoids
  // mixing it into synchronous logic.
  assign w_cmdFire  = (r_state == IDLE)  & w_anyReq & bus.mem_cmd_ready;
  assign w_dataFire = (r_state == WDATA) & w_ownerValid & bus.mem_data_ready;

  // Arbitration FSM: rotate priority on each accepted command, lock the data
  // channel for a write burst and count beats until the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_beatCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmdFire) begin
            r_ptr <= ~w_winner;
            if (w_cmdRw) begin
              r_owner   <= w_winner;
              r_beatCnt <= '0;
              r_state   <= WDATA;
            end
          end
        end
        WDATA: begin
          if (w_dataFire) begin
            if (r_beatCnt == LAST_BEAT) begin
              r_beatCnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_beatCnt <= r_beatCnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reset, single read, contention,
// backpressure, write burst with response overlap and mid-burst reset.
module tb_mem_req_arbiter;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  mem_req_arbiter_if bus ();

  mem_req_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input int client, input logic valid, input logic [25:0] addr,
                               input logic [4:0] tag, input logic rw);
    if (client == 0) begin
      bus.c0_cmd_valid = valid; bus.c0_cmd_addr = addr;
      bus.c0_cmd_tag   = tag;   bus.c0_cmd_rw   = rw;
    end else begin
      bus.c1_cmd_valid = valid; bus.c1_cmd_addr = addr;
      bus.c1_cmd_tag   = tag;   bus.c1_cmd_rw   = rw;
    end
  endtask

  task automatic clearInputs();
    applyStimulus(0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 1'b0);
    bus.c0_data_valid  = 1'b0; bus.c0_data_bits = '0;
    bus.c1_data_valid  = 1'b0; bus.c1_data_bits = '0;
    bus.mem_cmd_ready  = 1'b1;
    bus.mem_data_ready = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.mem_resp_tag   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1;
    clearInputs();

    // Reset: handshakes silenced even with requests present; responses still route.
    applyStimulus(0, 1'b1, 26'h100, 5'd3, 1'b0);
    bus.c1_data_valid  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_tag   = 6'h20;
    #2;
    checkOutput("rst_mem_cmd_valid", bus.mem_cmd_valid, 1'b0);
    checkOutput("rst_c0_cmd_ready", bus.c0_cmd_ready, 1'b0);
    checkOutput("rst_c1_cmd_ready", bus.c1_cmd_ready, 1'b0);
    checkOutput("rst_mem_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("rst_c1_data_ready", bus.c1_data_ready, 1'b0);
    checkOutput("rst_c1_resp_valid", bus.c1_resp_valid, 1'b1);
    checkOutput("rst_c0_resp_valid", bus.c0_resp_valid, 1'b0);
    step();
    step();
    reset = 1'b0;
    clearInputs();

    // Single read from c0.
    applyStimulus(0, 1'b1, 26'h100, 5'd3, 1'b0);
    settle();
    checkOutput("rd_mem_cmd_valid", bus.mem_cmd_valid, 1'b1);
    checkOutput("rd_mem_cmd_addr", bus.mem_cmd_addr, 26'h100);
    checkOutput("rd_mem_cmd_tag", bus.mem_cmd_tag, 6'h03);
    checkOutput("rd_mem_cmd_rw", bus.mem_cmd_rw, 1'b0);
    checkOutput("rd_c0_cmd_ready", bus.c0_cmd_ready, 1'b1);
    checkOutput("rd_c1_cmd_ready", bus.c1_cmd_ready, 1'b0);
    step();
    applyStimulus(0, 1'b0, '0, '0, 1'b0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_tag   = 6'h03;
    bus.mem_resp_data  = 128'hDEAD_BEEF;
    settle();
    checkOutput("rd_c0_resp_valid", bus.c0_resp_valid, 1'b1);
    checkOutput("rd_c0_resp_tag", bus.c0_resp_tag, 5'd3);
    checkOutput("rd_c0_resp_data", bus.c0_resp_data, 128'hDEAD_BEEF);
    checkOutput("rd_c1_resp_valid", bus.c1_resp_valid, 1'b0);
    checkOutput("rd_idle_cmd_valid", bus.mem_cmd_valid, 1'b0);
    bus.mem_resp_valid = 1'b0;

    // Contention straight out of reset: c0 first, then c1, then c0 again.
    pulseReset();
    applyStimulus(0, 1'b1, 26'h10, 5'd1, 1'b0);
    applyStimulus(1, 1'b1, 26'h20, 5'd2, 1'b0);
    settle();
    checkOutput("ct1_mem_cmd_tag", bus.mem_cmd_tag, 6'h01);
    checkOutput("ct1_c0_cmd_ready", bus.c0_cmd_ready, 1'b1);
    checkOutput("ct1_c1_cmd_ready", bus.c1_cmd_ready, 1'b0);
    step();
    applyStimulus(0, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("ct2_mem_cmd_tag", bus.mem_cmd_tag, 6'h22);
    checkOutput("ct2_mem_cmd_addr", bus.mem_cmd_addr, 26'h20);
    checkOutput("ct2_c1_cmd_ready", bus.c1_cmd_ready, 1'b1);
    checkOutput("ct2_c0_cmd_ready", bus.c0_cmd_ready, 1'b0);
    step();
    applyStimulus(0, 1'b1, 26'h14, 5'd4, 1'b0);
    settle();
    checkOutput("ct3_mem_cmd_tag", bus.mem_cmd_tag, 6'h04);
    checkOutput("ct3_c0_cmd_ready", bus.c0_cmd_ready, 1'b1);
    step();
    clearInputs();

    // Backpressure: ptr favours c1; five stalled cycles must leave everything stable.
    bus.mem_cmd_ready = 1'b0;
    applyStimulus(0, 1'b1, 26'h50, 5'd5, 1'b0);
    applyStimulus(1, 1'b1, 26'h60, 5'd6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      settle();
      checkOutput("bp_mem_cmd_valid", bus.mem_cmd_valid, 1'b1);
      checkOutput("bp_mem_cmd_tag", bus.mem_cmd_tag, 6'h26);
      checkOutput("bp_mem_cmd_addr", bus.mem_cmd_addr, 26'h60);
      checkOutput("bp_c1_cmd_ready", bus.c1_cmd_ready, 1'b0);
      step();
    end
    bus.mem_cmd_ready = 1'b1;
    settle();
    checkOutput("bp_release_c1_ready", bus.c1_cmd_ready, 1'b1);
    checkOutput("bp_release_tag", bus.mem_cmd_tag, 6'h26);
    step();
    applyStimulus(1, 1'b0, '0, '0, 1'b0);
    settle();
    checkOutput("bp_next_tag", bus.mem_cmd_tag, 6'h05);
    checkOutput("bp_next_c0_ready", bus.c0_cmd_ready, 1'b1);
    step();
    clearInputs();

    // Write burst from c1 with c0 read waiting and mem_data_ready toggling.
    applyStimulus(1, 1'b1, 26'h300, 5'd7, 1'b1);
    applyStimulus(0, 1'b1, 26'h40, 5'd1, 1'b0);
    bus.c1_data_valid = 1'b1;
    bus.c1_data_bits  = 128'hA;
    settle();
    checkOutput("wr_mem_cmd_tag", bus.mem_cmd_tag, 6'h27);
    checkOutput("wr_mem_cmd_rw", bus.mem_cmd_rw, 1'b1);
    checkOutput("wr_c1_cmd_ready", bus.c1_cmd_ready, 1'b1);
    checkOutput("wr_early_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("wr_early_c1_data_ready", bus.c1_data_ready, 1'b0);
    step();
    applyStimulus(1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.c1_data_bits   = 128'(32'hA + i);
      bus.mem_data_ready = 1'b0;
      settle();
      checkOutput("wr_stall_data_valid", bus.mem_data_valid, 1'b1);
      checkOutput("wr_stall_data_bits", bus.mem_data_bits, 128'(32'hA + i));
      checkOutput("wr_stall_c1_data_ready", bus.c1_data_ready, 1'b0);
      checkOutput("wr_c0_blocked", bus.c0_cmd_ready, 1'b0);
      checkOutput("wr_cmd_valid_low", bus.mem_cmd_valid, 1'b0);
      step();
      bus.mem_data_ready = 1'b1;
      if (i == 1) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = 6'h25;
        bus.mem_resp_data  = 128'h77;
      end
      settle();
      checkOutput("wr_beat_c1_data_ready", bus.c1_data_ready, 1'b1);
      checkOutput("wr_beat_c0_data_ready", bus.c0_data_ready, 1'b0);
      checkOutput("wr_beat_bits", bus.mem_data_bits, 128'(32'hA + i));
      if (i == 1) begin
        checkOutput("ov_c1_resp_valid", bus.c1_resp_valid, 1'b1);
        checkOutput("ov_c1_resp_tag", bus.c1_resp_tag, 5'd5);
        checkOutput("ov_c0_resp_valid", bus.c0_resp_valid, 1'b0);
      end
      step();
      bus.mem_resp_valid = 1'b0;
    end
    settle();
    checkOutput("wr_done_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("wr_done_c1_data_ready", bus.c1_data_ready, 1'b0);
    checkOutput("wr_done_cmd_valid", bus.mem_cmd_valid, 1'b1);
    checkOutput("wr_done_cmd_tag", bus.mem_cmd_tag, 6'h01);
    checkOutput("wr_done_c0_ready", bus.c0_cmd_ready, 1'b1);
    step();
    clearInputs();

    // Mid-burst reset after two beats, then a full post-reset burst.
    applyStimulus(0, 1'b1, 26'h500, 5'd9, 1'b1);
    settle();
    checkOutput("mr_cmd_tag", bus.mem_cmd_tag, 6'h09);
    step();
    applyStimulus(0, 1'b0, '0, '0, 1'b0);
    bus.c0_data_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.c0_data_bits = 128'(32'hA0 + i);
      settle();
      checkOutput("mr_beat_c0_data_ready", bus.c0_data_ready, 1'b1);
      step();
    end
    applyStimulus(1, 1'b1, 26'h600, 5'd3, 1'b0);
    settle();
    checkOutput("mr_locked_cmd_valid", bus.mem_cmd_valid, 1'b0);
    reset = 1'b1;
    settle();
    checkOutput("mr_rst_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("mr_rst_c0_data_ready", bus.c0_data_ready, 1'b0);
    checkOutput("mr_rst_c1_data_ready", bus.c1_data_ready, 1'b0);
    checkOutput("mr_rst_cmd_valid", bus.mem_cmd_valid, 1'b0);
    checkOutput("mr_rst_c0_cmd_ready", bus.c0_cmd_ready, 1'b0);
    checkOutput("mr_rst_c1_cmd_ready", bus.c1_cmd_ready, 1'b0);
    step();
    reset = 1'b0;
    applyStimulus(1, 1'b0, '0, '0, 1'b0);
    applyStimulus(0, 1'b1, 26'h700, 5'd2, 1'b1);
    settle();
    checkOutput("pr_idle_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("pr_cmd_valid", bus.mem_cmd_valid, 1'b1);
    checkOutput("pr_cmd_tag", bus.mem_cmd_tag, 6'h02);
    step();
    applyStimulus(0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.c0_data_bits = 128'(32'hB0 + i);
      settle();
      checkOutput("pr_beat_data_valid", bus.mem_data_valid, 1'b1);
      checkOutput("pr_beat_c0_data_ready", bus.c0_data_ready, 1'b1);
      checkOutput("pr_beat_bits", bus.mem_data_bits, 128'(32'hB0 + i));
      step();
    end
    applyStimulus(1, 1'b1, 26'h800, 5'd4, 1'b0);
    settle();
    checkOutput("pr_done_data_valid", bus.mem_data_valid, 1'b0);
    checkOutput("pr_done_c0_data_ready", bus.c0_data_ready, 1'b0);
    checkOutput("pr_done_cmd_valid", bus.mem_cmd_valid, 1'b1);
    checkOutput("pr_done_cmd_tag", bus.mem_cmd_tag, 6'h24);
    step();
    clearInputs();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
